// File: rtl/serial_word_deframer.sv
// serial_word_deframer
// Recovers parallel words from a serial bit stream. The frame is a start bit (1),
// then WIDTH data bits sent MSB first, then a stop bit (0). Each good frame updates
// dout, pulses valid for one clock and increments frame_cnt. A bad frame pulses
// frm_err for one clock and changes neither dout nor frame_cnt.
// Optional build macro DEFRAMER_PARITY_EN inserts one even-parity bit between the
// data bits and the stop bit.
//
// state  | meaning
// IDLE   | waiting for a start bit (the line idles at 0)
// DATA   | shifting in the WIDTH data bits
// PARITY | sampling the even-parity bit (only with DEFRAMER_PARITY_EN)
// STOP   | checking the stop bit, then finishing the frame
module serial_word_deframer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inp,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             frm_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BCW = $clog2(WIDTH + 1);

`ifdef DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BCW-1:0]   bit_cnt;
`ifdef DEFRAMER_PARITY_EN
  logic             par_acc;
  logic             par_bad;
`endif

  // busy is a direct decode of the state register, so it has no extra latency
  assign busy = (state != IDLE);

  // Frame FSM. The strobes default low on every edge, so each one lasts exactly
  // one clock even when en is low on the following edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frm_err   <= 1'b0;
      frame_cnt <= '0;
`ifdef DEFRAMER_PARITY_EN
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
`endif
    end else begin
      valid   <= 1'b0;
      frm_err <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (inp) begin
              state   <= DATA;
              bit_cnt <= '0;
`ifdef DEFRAMER_PARITY_EN
              par_acc <= 1'b0;
`endif
            end
          end
          DATA: begin
            shift_reg <= {shift_reg[WIDTH-2:0], inp};
            bit_cnt   <= bit_cnt + BCW'(1);
`ifdef DEFRAMER_PARITY_EN
            par_acc   <= par_acc ^ inp;
            if (bit_cnt == BCW'(WIDTH - 1)) state <= PARITY;
`else
            if (bit_cnt == BCW'(WIDTH - 1)) state <= STOP;
`endif
          end
`ifdef DEFRAMER_PARITY_EN
          PARITY: begin
            // Even parity: data bits XOR parity bit must come to 0
            par_bad <= par_acc ^ inp;
            state   <= STOP;
          end
`endif
          STOP: begin
            // A bad stop bit just ends the frame; it is never taken as a new start bit
`ifdef DEFRAMER_PARITY_EN
            if (!inp && !par_bad) begin
`else
            if (!inp) begin
`endif
              dout      <= shift_reg;
              valid     <= 1'b1;
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              frm_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_deframer.sv
// Testbench for serial_word_deframer (WIDTH=6, CNT_W=8).
// The stimulus pushes the expected outcome of each frame into a queue. A monitor
// running on the falling edge pops one entry for every valid or frm_err strobe.
module tb_serial_word_deframer;

  logic       clk = 1'b0;
  logic       rst, en, inp;
  logic [5:0] dout;
  logic       valid, frm_err, busy;
  logic [7:0] frame_cnt;

  serial_word_deframer #(.WIDTH(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .dout(dout), .valid(valid),
    .frm_err(frm_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       good;
    logic [5:0] word;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic       bits[$];
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         n_err = 0;
  logic [5:0] exp_dout = '0;
  logic [7:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe consumes one scoreboard entry
  always @(negedge clk) begin
    if (valid === 1'b1 && frm_err === 1'b1) check("strobe_overlap", 1, 0);
    if (valid === 1'b1 || frm_err === 1'b1) begin
      if (valid) n_valid++;
      if (frm_err) n_err++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", {valid, frm_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {valid, frm_err}, e.good ? 2'b10 : 2'b01);
        check("dout", dout, e.word);
        check("frame_cnt", frame_cnt, e.cnt);
      end
    end
  end

  // Builds the bit sequence of one frame; par_flip inverts the parity bit when present
  task automatic make_bits(input logic [5:0] w, input logic stop, input logic par_flip);
    bits.delete();
    bits.push_back(1'b1);
    for (int i = 5; i >= 0; i--) bits.push_back(w[i]);
`ifdef DEFRAMER_PARITY_EN
    bits.push_back((^w) ^ par_flip);
`endif
    bits.push_back(stop);
  endtask

  // Records the expected outcome of a frame and updates the reference model
  task automatic expect_frame(input logic [5:0] w, input logic good);
    exp_t e;
    if (good) begin
      exp_dout = w;
      exp_cnt  = exp_cnt + 8'd1;
    end
    e.good = good;
    e.word = exp_dout;
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic clock_bit(input logic b);
    inp = b;
    en  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [5:0] w, input logic stop, input logic par_flip);
    make_bits(w, stop, par_flip);
    expect_frame(w, !stop && !par_flip);
    foreach (bits[i]) clock_bit(bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clock_bit(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inp = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_dout = '0;
    exp_cnt  = '0;
  endtask

  initial begin
    int v0, e0;
    rst = 1'b1;
    en  = 1'b0;
    inp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    idle(2);

    // Good frame: the strobe appears right after the edge that samples the stop bit
    send_frame(6'b101100, 1'b0, 1'b0);
    check("t1_valid_now", valid, 1);
    check("t1_busy_after", busy, 0);
    idle(1);
    check("t1_valid_one_clk", valid, 0);
    idle(2);

    // Bad stop bit: frm_err only, and the stop bit is not taken as a new start bit
    send_frame(6'b110011, 1'b1, 1'b0);
    check("t2_frm_err_now", frm_err, 1);
    check("t2_busy_idle", busy, 0);
    idle(1);
    check("t2_frm_err_one_clk", frm_err, 0);
    check("t2_dout_kept", dout, 6'b101100);
    check("t2_cnt_kept", frame_cnt, 1);

    // en toggles every clock and each bit is held for two clocks
    make_bits(6'b010101, 1'b0, 1'b0);
    expect_frame(6'b010101, 1'b1);
    foreach (bits[i]) begin
      inp = bits[i];
      en  = 1'b1;
      @(posedge clk);
      #1;
      check("t3_busy_en1", busy, (i == bits.size() - 1) ? 0 : 1);
      if (i == bits.size() - 1) check("t3_valid_on", valid, 1);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("t3_busy_en0", busy, (i == bits.size() - 1) ? 0 : 1);
      if (i == bits.size() - 1) check("t3_valid_off", valid, 0);
    end
    idle(2);

    // Reset partway through the data bits, then a clean frame
    make_bits(6'b111000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clock_bit(bits[i]);
    check("t4_busy_mid", busy, 1);
    do_reset();
    check("t4_busy_rst", busy, 0);
    check("t4_dout_rst", dout, 0);
    check("t4_cnt_rst", frame_cnt, 0);
    idle(10);
    send_frame(6'b111000, 1'b0, 1'b0);
    idle(1);
    check("t4_dout", dout, 6'b111000);
    check("t4_cnt", frame_cnt, 1);

    // 256 back-to-back good frames make the counter wrap to 0
    do_reset();
    idle(1);
    v0 = n_valid;
    e0 = n_err;
    for (int k = 0; k < 256; k++) send_frame(6'(k * 7 + 3), 1'b0, 1'b0);
    idle(2);
    check("t5_cnt_wrap", frame_cnt, 0);
    check("t5_valid_count", n_valid - v0, 256);
    check("t5_no_err", n_err - e0, 0);

`ifdef DEFRAMER_PARITY_EN
    send_frame(6'b101100, 1'b0, 1'b0);
    idle(1);
    check("tp_dout", dout, 6'b101100);
    send_frame(6'b011010, 1'b0, 1'b1);
    idle(1);
    check("tp_dout_kept", dout, 6'b101100);
`endif

    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_deframer.md
Name: serial_word_deframer

Overview:
- Downstream consumer of the 6-bit serial shift register's serial output `o`.
- Detects a start bit, then shifts in WIDTH data bits MSB-first and checks a stop bit.
- Presents the assembled parallel word with a one-cycle valid strobe, a framing-error strobe and a running count of good frames.
- Turns the serial bit stream back into words for the next parallel stage.

Parameters:
- WIDTH, 6, number of data bits per frame (2..16).
- CNT_W, 8, width of good-frame counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  bit-sample enable; a serial bit is consumed only on edges where en=1.
- inp  input  1  serial data, driven directly by the shift register output.
- dout  output  WIDTH  last good received word, MSB = first data bit received.
- valid  output  1  one-clk pulse: dout updated with a good frame.
- frm_err  output  1  one-clk pulse: bad stop bit (or parity, if enabled).
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_cnt  output  CNT_W  count of good frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, shift reg=0, bit counter=0, dout=0, valid=0, frm_err=0, busy=0, frame_cnt=0. rst overrides en and inp.
- Reset mid-frame aborts the frame: no valid, no frm_err.
- Frame format on the inp bit stream: start bit 1, then WIDTH data bits MSB-first, then stop bit 0.
- Edges with en=0: state, shift reg and counter hold. valid and frm_err are still forced to 0 on every edge that does not generate them, so each strobe lasts exactly one clk.
- FSM states IDLE, DATA, STOP. All transitions below occur only on en=1 edges:
  - IDLE: inp=1 -> DATA, bit counter=0. inp=0 -> stay in IDLE (line idle at 0).
  - DATA: shift reg <= {shift reg[WIDTH-2:0], inp}; counter++. When the counter was WIDTH-1 -> STOP.
  - STOP, inp=0 (good frame): dout <= shift reg; valid=1 for one clk; frame_cnt++ (wraps 2^CNT_W-1 -> 0); -> IDLE.
  - STOP, inp=1 (bad stop bit): frm_err=1 for one clk; dout and frame_cnt unchanged; -> IDLE. The bad stop bit is not reinterpreted as a start bit.
- Latency: valid is asserted after the edge that samples the stop bit. A frame with en=1 every cycle is therefore WIDTH+2 sampled edges from the start bit to valid.
- Back-to-back frames: a start bit on the en edge immediately after the STOP edge is accepted. No idle gap is required.
- busy=1 exactly while in DATA or STOP.
- valid and frm_err are never high together.

Optional Feature:
- Macro: DEFRAMER_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, carrying one even-parity bit, so the frame is WIDTH+3 bits.
  - Parity rule: XOR of the data bits and the parity bit must be 0.
  - Parity mismatch: the frame still runs through STOP, then frm_err=1 and valid=0, whatever the stop bit value.
- When undefined: no PARITY state, no parity logic, frame is WIDTH+2 bits.

Test Plan:
- WIDTH=6, en=1 constant, inp = 1,1,0,1,1,0,0,0 -> valid pulses one clk after the 8th edge; dout=6'b101100; frame_cnt=1; frm_err=0.
- Same frame with stop bit 1 -> frm_err pulses one clk; valid=0; dout keeps its prior value; frame_cnt unchanged; state IDLE.
- en toggled 1,0,1,0 each cycle with every bit held for 2 clks, frame 1,010101,0 -> dout=6'b010101; busy high throughout the frame; valid pulse exactly one clk wide.
- rst asserted after the 3rd data bit, then a clean frame 1,111000,0 -> no strobe from the aborted frame; after reset dout=6'b111000, frame_cnt=1.
- 256 consecutive good back-to-back frames with CNT_W=8 -> frame_cnt wraps to 0; 256 valid pulses; no frm_err.
- DEFRAMER_PARITY_EN defined, frame 1,101100,1,0 -> valid, dout=6'b101100. Parity bit 0 instead -> frm_err, no valid.
